// File: rtl/mem_bist_pkg.sv
// Shared definitions for the 32x8 memory BIST controller: widths, FSM states,
// pattern mode encodings and the pattern generator.
package mem_bist_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;
    localparam int CNT_W  = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } bist_state_e;

    localparam logic [1:0] MODE_ADDR  = 2'd0;
    localparam logic [1:0] MODE_CHECK = 2'd1;
    localparam logic [1:0] MODE_ASCII = 2'd2;
    localparam logic [1:0] MODE_INV   = 2'd3;

    // Expected memory content for a location under a given pattern mode.
    function automatic logic [DATA_W-1:0] bist_pattern(input logic [1:0] mode,
                                                       input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] addr_ext;
        logic [DATA_W-1:0] result;
        addr_ext = {{(DATA_W-ADDR_W){1'b0}}, addr};
        case (mode)
            MODE_ADDR:  result = addr_ext;
            MODE_CHECK: result = addr[0] ? 8'hAA : 8'h55;
            MODE_ASCII: result = 8'h40 + addr_ext;
            MODE_INV:   result = ~addr_ext;
            default:    result = addr_ext;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mem_bist_cmp.sv
// Read-back compare pipeline: stage 1 captures the issued read address, stage 2
// checks the memory's registered read data against the expected pattern and
// accumulates the mismatch count and the first failing address.
module mem_bist_cmp
    import mem_bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              valid,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [CNT_W-1:0]  err_count_nxt
);

    logic              s1_valid_r;
    logic [ADDR_W-1:0] s1_addr_r;
    logic [DATA_W-1:0] expected_s;
    logic              mismatch_s;
    logic              s1_valid_nxt_s;
    logic [ADDR_W-1:0] first_nxt_s;

    // Compare logic and next values of the result registers.
    always_comb begin
        expected_s     = bist_pattern(mode, s1_addr_r);
        mismatch_s     = s1_valid_r && (data_out != expected_s);
        err_count_nxt  = err_count;
        first_nxt_s    = first_err_addr;
        s1_valid_nxt_s = valid;
        if (clr) begin
            err_count_nxt  = {CNT_W{1'b0}};
            first_nxt_s    = {ADDR_W{1'b0}};
            s1_valid_nxt_s = 1'b0;
        end else if (mismatch_s) begin
            err_count_nxt = err_count + 6'd1;
            if (err_count == 6'd0) begin
                first_nxt_s = s1_addr_r;
            end else begin
                first_nxt_s = first_err_addr;
            end
        end else begin
            err_count_nxt = err_count;
            first_nxt_s   = first_err_addr;
        end
    end

    // Pipeline stage 1 plus result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r     <= 1'b0;
            s1_addr_r      <= {ADDR_W{1'b0}};
            err_count      <= {CNT_W{1'b0}};
            first_err_addr <= {ADDR_W{1'b0}};
        end else begin
            s1_valid_r     <= s1_valid_nxt_s;
            s1_addr_r      <= addr;
            err_count      <= err_count_nxt;
            first_err_addr <= first_nxt_s;
        end
    end

endmodule

// File: rtl/mem_bist_ctrl.sv
// BIST master for the 32x8 single-port memory: writes a pattern to every
// location, reads everything back, and reports pass/fail, error count and the
// first failing address. All outputs are registered.
module mem_bist_ctrl
    import mem_bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    bist_state_e       state_r;
    bist_state_e       state_nxt_s;
    logic [1:0]        mode_r;
    logic [1:0]        mode_nxt_s;
    logic              busy_nxt_s;
    logic              done_nxt_s;
    logic              pass_nxt_s;
    logic              read_nxt_s;
    logic              write_nxt_s;
    logic [ADDR_W-1:0] addr_nxt_s;
    logic [DATA_W-1:0] data_in_nxt_s;
    logic              clr_s;
    logic [CNT_W-1:0]  err_count_nxt_s;

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so that every port comes straight from a flop.
    always_comb begin
        state_nxt_s   = state_r;
        mode_nxt_s    = mode_r;
        busy_nxt_s    = busy;
        done_nxt_s    = 1'b0;
        pass_nxt_s    = pass;
        read_nxt_s    = 1'b0;
        write_nxt_s   = 1'b0;
        addr_nxt_s    = addr;
        data_in_nxt_s = data_in;
        clr_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s   = ST_WRITE;
                    mode_nxt_s    = mode;
                    clr_s         = 1'b1;
                    pass_nxt_s    = 1'b0;
                    busy_nxt_s    = 1'b1;
                    write_nxt_s   = 1'b1;
                    addr_nxt_s    = {ADDR_W{1'b0}};
                    data_in_nxt_s = bist_pattern(mode, {ADDR_W{1'b0}});
                end else begin
                    busy_nxt_s = 1'b0;
                end
            end
            ST_WRITE: begin
                if (addr == LAST_ADDR) begin
                    // Write data stays at its last value through the read phase.
                    state_nxt_s = ST_READ;
                    read_nxt_s  = 1'b1;
                    addr_nxt_s  = {ADDR_W{1'b0}};
                end else begin
                    write_nxt_s   = 1'b1;
                    addr_nxt_s    = addr + 5'd1;
                    data_in_nxt_s = bist_pattern(mode_r, addr + 5'd1);
                end
            end
            ST_READ: begin
                if (addr == LAST_ADDR) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    read_nxt_s = 1'b1;
                    addr_nxt_s = addr + 5'd1;
                end
            end
            ST_DRAIN: begin
                // The final compare lands on the same edge that enters DONE,
                // so pass is taken from the compare block's next count.
                state_nxt_s = ST_DONE;
                busy_nxt_s  = 1'b0;
                done_nxt_s  = 1'b1;
                pass_nxt_s  = (err_count_nxt_s == 6'd0);
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                busy_nxt_s  = 1'b0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State register and registered bus/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            mode_r  <= 2'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            read    <= 1'b0;
            write   <= 1'b0;
            addr    <= {ADDR_W{1'b0}};
            data_in <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            mode_r  <= mode_nxt_s;
            busy    <= busy_nxt_s;
            done    <= done_nxt_s;
            pass    <= pass_nxt_s;
            read    <= read_nxt_s;
            write   <= write_nxt_s;
            addr    <= addr_nxt_s;
            data_in <= data_in_nxt_s;
        end
    end

    mem_bist_cmp u_cmp (
        .clk            (clk),
        .rst            (rst),
        .clr            (clr_s),
        .valid          (read),
        .addr           (addr),
        .mode           (mode_r),
        .data_out       (data_out),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .err_count_nxt  (err_count_nxt_s)
    );

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Self-checking bench for mem_bist_ctrl with a behavioural 32x8 memory that
// supports stuck-at (OR) and bit-flip (XOR) faults on read.
module tb_mem_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic       busy, done, pass, read, write;
    logic [5:0] err_count;
    logic [4:0] first_err_addr, addr;
    logic [7:0] data_in, data_out;

    logic [7:0] mem   [32];
    logic [7:0] f_or  [32];
    logic [7:0] f_xor [32];

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0] mode;
        logic [4:0] or_addr;  logic [7:0] or_mask;
        logic [4:0] xa_addr;  logic [7:0] xa_mask;
        logic [4:0] xb_addr;  logic [7:0] xb_mask;
        logic [7:0] all_xor;
        logic [5:0] exp_err;
        logic [4:0] exp_first;
        logic       exp_pass;
    } vec_t;

    typedef struct {
        logic       busy, done, read, write;
        logic [4:0] addr;
        logic [7:0] data;
        logic       chk_addr, chk_data;
    } bus_t;

    vec_t vecs [9];
    bus_t exp_q [$];

    mem_bist_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_addr(first_err_addr), .read(read), .write(write),
        .addr(addr), .data_in(data_in), .data_out(data_out)
    );

    always #5 clk = ~clk;

    // Behavioural memory with registered read and injectable read faults.
    always @(posedge clk) begin
        if (write) mem[addr] <= data_in;
        if (read)  data_out <= (mem[addr] | f_or[addr]) ^ f_xor[addr];
    end

    // Independent reference for the four data patterns.
    function automatic logic [7:0] ref_pattern(input logic [1:0] m, input int a);
        case (m)
            2'd0:    return 8'(a);
            2'd1:    return ((a % 2) == 1) ? 8'hAA : 8'h55;
            2'd2:    return 8'h40 | 8'(a);
            default: return 8'hFF - 8'(a);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " pass"}, 32'(pass), 32'd0);
        check({tag, " err_count"}, 32'(err_count), 32'd0);
        check({tag, " first_err_addr"}, 32'(first_err_addr), 32'd0);
        check({tag, " read"}, 32'(read), 32'd0);
        check({tag, " write"}, 32'(write), 32'd0);
        check({tag, " addr"}, 32'(addr), 32'd0);
        check({tag, " data_in"}, 32'(data_in), 32'd0);
    endtask

    task automatic set_faults(input vec_t v);
        for (int i = 0; i < 32; i++) begin
            f_or[i]  = 8'h00;
            f_xor[i] = v.all_xor;
        end
        f_or[v.or_addr]  = f_or[v.or_addr] | v.or_mask;
        f_xor[v.xa_addr] = f_xor[v.xa_addr] ^ v.xa_mask;
        f_xor[v.xb_addr] = f_xor[v.xb_addr] ^ v.xb_mask;
    endtask

    // Push the expected bus activity for one full run (cycles after E0..E66).
    task automatic push_run(input logic [1:0] m);
        bus_t e;
        for (int k = 0; k < 67; k++) begin
            e.busy     = (k < 65);
            e.done     = (k == 65);
            e.write    = (k < 32);
            e.read     = (k >= 32) && (k < 64);
            e.addr     = (k < 32) ? 5'(k) : 5'(k - 32);
            e.data     = ref_pattern(m, (k < 32) ? k : 31);
            e.chk_addr = (k < 64);
            e.chk_data = (k < 64);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_case(input vec_t v, input bit glitch);
        bus_t e;
        int   dones;
        set_faults(v);
        @(negedge clk);
        start = 1'b1;
        mode  = v.mode;
        push_run(v.mode);
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int k = 0; k < 67; k++) begin
            start = glitch && (k == 10);
            if (exp_q.size() == 0) begin
                check("scoreboard underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("busy", 32'(busy), 32'(e.busy));
                check("done", 32'(done), 32'(e.done));
                check("read", 32'(read), 32'(e.read));
                check("write", 32'(write), 32'(e.write));
                check("rw exclusive", 32'(read & write), 32'd0);
                if (e.chk_addr) check("addr", 32'(addr), 32'(e.addr));
                if (e.chk_data) check("data_in", 32'(data_in), 32'(e.data));
            end
            if (done) dones++;
            if (k == 65) begin
                check("err_count", 32'(err_count), 32'(v.exp_err));
                check("first_err_addr", 32'(first_err_addr), 32'(v.exp_first));
                check("pass", 32'(pass), 32'(v.exp_pass));
            end
            if (k == 66) check("pass held", 32'(pass), 32'(v.exp_pass));
            @(negedge clk);
        end
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            if (done) dones++;
            check("idle after run busy", 32'(busy), 32'd0);
            @(negedge clk);
        end
        check("done pulse count", 32'(dones), 32'd1);
    endtask

    initial begin
        vecs[0] = '{2'd0, 5'd0, 8'h00, 5'd0, 8'h00, 5'd0, 8'h00, 8'h00, 6'd0, 5'd0, 1'b1};
        vecs[1] = '{2'd2, 5'd0, 8'h00, 5'd0, 8'h00, 5'd0, 8'h00, 8'h00, 6'd0, 5'd0, 1'b1};
        vecs[2] = '{2'd1, 5'd7, 8'h01, 5'd0, 8'h00, 5'd0, 8'h00, 8'h00, 6'd1, 5'd7, 1'b0};
        vecs[3] = '{2'd3, 5'd0, 8'h00, 5'd20, 8'h01, 5'd3, 8'h10, 8'h00, 6'd2, 5'd3, 1'b0};
        vecs[4] = '{2'd1, 5'd0, 8'h00, 5'd0, 8'h00, 5'd0, 8'h00, 8'h00, 6'd0, 5'd0, 1'b1};
        vecs[5] = '{2'd3, 5'd0, 8'h00, 5'd0, 8'h00, 5'd0, 8'h00, 8'h00, 6'd0, 5'd0, 1'b1};
        vecs[6] = '{2'd0, 5'd0, 8'h00, 5'd0, 8'h00, 5'd0, 8'h00, 8'hFF, 6'd32, 5'd0, 1'b0};
        vecs[7] = '{2'd2, 5'd0, 8'h00, 5'd31, 8'h80, 5'd0, 8'h00, 8'h00, 6'd1, 5'd31, 1'b0};
        vecs[8] = '{2'd1, 5'd6, 8'h01, 5'd0, 8'h00, 5'd0, 8'h00, 8'h00, 6'd0, 5'd0, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        mode  = 2'd0;
        for (int i = 0; i < 32; i++) begin
            f_or[i]  = 8'h00;
            f_xor[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;

        // Table-driven runs.
        for (int i = 0; i < 9; i++) run_case(vecs[i], 1'b0);

        // Start pulsed mid-run is ignored; exactly one done.
        run_case(vecs[3], 1'b1);

        // Reset during the read phase.
        set_faults(vecs[0]);
        @(negedge clk);
        start = 1'b1;
        mode  = 2'd0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40; k++) @(negedge clk);
        check("pre-reset read", 32'(read), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("mid-run reset");
        run_case(vecs[0], 1'b0);

        // Reset and start on the same edge: nothing starts.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            check("rst+start busy", 32'(busy), 32'd0);
            check("rst+start bus", 32'({read, write}), 32'd0);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
